// File: rtl/fp_mat_stream_out.sv
// Drain stage of the fixed-point matmul: captures a whole result matrix, requantises it, streams it row-major.
// Latency: first beat appears the cycle after the load handshake; then one element per cycle.
// Backpressure: beat and indices hold stable while out_valid & !out_ready; no capture until the stream ends.
module fp_mat_stream_out #(
    parameter int ROW   = 8,
    parameter int COL   = 8,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       load_valid,
    output logic                                       load_ready,
    input  logic [ROW*COL*IN_W-1:0]                    mat_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_W-1:0]                           out_data,
    output logic [((ROW > 1) ? $clog2(ROW) : 1)-1:0]   out_row,
    output logic [((COL > 1) ? $clog2(COL) : 1)-1:0]   out_col,
    output logic                                       out_last,
    output logic                                       sat_flag
);
    localparam int N  = ROW * COL;
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int SH = (IN_W - OUT_W) / 2;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [PW-1:0]     ptr_q;
    logic              sat_q;
    logic [OUT_W-1:0]  buf_q [N];
    logic [OUT_W-1:0]  q_vec [N];
    logic [N-1:0]      sat_vec;
    logic              cap;
    logic              adv;

    for (genvar i = 0; i < N; i++) begin : g_rq
        logic signed [IN_W-1:0] x;
        assign x = mat_in[i*IN_W +: IN_W];
        if (SH == 0) begin : g_pass
            assign q_vec[i]   = x;
            assign sat_vec[i] = 1'b0;
        end else begin : g_round
            // One extra bit so the rounding add cannot wrap.
            localparam logic signed [IN_W:0] RND  = {{IN_W{1'b0}}, 1'b1} << (SH - 1);
            localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
            logic signed [IN_W:0] xe;
            logic signed [IN_W:0] t;
            assign xe = $signed({x[IN_W-1], x}) + RND;
            assign t  = xe >>> SH;
            assign sat_vec[i] = (t > MAXV) || (t < MINV);
            assign q_vec[i]   = (t > MAXV) ? {1'b0, {(OUT_W-1){1'b1}}} :
                                (t < MINV) ? {1'b1, {(OUT_W-1){1'b0}}} :
                                t[OUT_W-1:0];
        end
    end

    assign load_ready = rst_n && (state_q == IDLE);
    assign out_valid  = (state_q == STREAM);
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = out_valid && (row_q == RW'(ROW - 1)) && (col_q == CW'(COL - 1));
    assign out_data   = out_valid ? buf_q[ptr_q] : '0;
    assign sat_flag   = sat_q;
    assign cap        = load_valid && load_ready;
    assign adv        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap)             state_d = STREAM;
            STREAM:  if (adv && out_last) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ptr_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                row_q <= '0;
                col_q <= '0;
                ptr_q <= '0;
                sat_q <= |sat_vec;
            end else if (adv) begin
                if (out_last) begin
                    row_q <= '0;
                    col_q <= '0;
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_q + PW'(1);
                    if (col_q == CW'(COL - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
            end
        end
    end

    // Buffer contents only matter once a capture has happened, so no reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            for (int i = 0; i < N; i++) buf_q[i] <= q_vec[i];
        end
    end
endmodule
